// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock, signed/unsigned per operand.
// Optional: define MUL_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    input  logic                 op1_signed,
    input  logic                 op2_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   res
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     res_q, res_d;
    logic              out_valid_q, out_valid_d;

    logic              op1_neg, op2_neg;
    logic [WIDTH-1:0]  op1_mag, op2_mag;
    logic [PW-1:0]     acc_step;
    logic [WIDTH-1:0]  mplier_step;
    logic              finish;

    always_comb begin
        // WIDTH-bit negate keeps the most negative value as 2^(WIDTH-1) when read unsigned
        op1_neg     = op1_signed & op1[WIDTH-1];
        op2_neg     = op2_signed & op2[WIDTH-1];
        op1_mag     = op1_neg ? (~op1 + 1'b1) : op1;
        op2_mag     = op2_neg ? (~op2 + 1'b1) : op2;
        acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_step = {1'b0, mplier_q[WIDTH-1:1]};
`ifdef MUL_SEQ_EARLY_EXIT_EN
        finish      = (cnt_q == LAST) || (mplier_step == '0);
`else
        finish      = (cnt_q == LAST);
`endif

        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, op1_mag};
                    mplier_d = op2_mag;
                    cnt_d    = '0;
                    neg_d    = op1_neg ^ op2_neg;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = {mcand_q[PW-2:0], 1'b0};
                mplier_d = mplier_step;
                cnt_d    = cnt_q + 1'b1;
                if (finish) begin
                    res_d       = neg_q ? (~acc_step + 1'b1) : acc_step;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // retire only; a new accept waits for the following edge in IDLE
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign res       = res_q;

endmodule
